// File: rtl/key_reset_sequencer.sv
// key_reset_sequencer
//   Board front end for the DE1-SoC push buttons. It debounces the raw
//   active-low keys into clean levels with one-cycle press/release pulses,
//   and sequences an active-low reset for the core. The core reset is held
//   low for a fixed number of cycles after power-on reset or after the
//   manual reset key is released.
//
//   Optional feature macro: KEY_SYNC_EN
//     defined   -> each key goes through a two-flop synchronizer before the
//                  debouncer, which adds two cycles of latency.
//     undefined -> keys are sampled directly. Use this only when the stimulus
//                  is already synchronous to clock_50.
module key_reset_sequencer #(
  parameter int N_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int RESET_HOLD_CYCLES = 5,
  parameter int RESET_KEY         = 0
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              rst_n_out,
  output logic              rst_done
);

  // Debounce counter counts 0..DEBOUNCE_CYCLES-1, so this width is enough.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The hold counter needs at least one bit, even when the hold is 1 cycle.
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  // Active-high "pressed" view of the raw pins.
  logic [N_KEYS-1:0] raw_s;
  // The sample that the debouncers actually see.
  logic [N_KEYS-1:0] samp_s;

  assign raw_s = ~key_n;

`ifdef KEY_SYNC_EN
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  // Two-flop synchronizer. On reset it reads "released".
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  assign samp_s = sync2_q;
`else
  assign samp_s = raw_s;
`endif

  // One independent debouncer per key channel.
  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : gen_ch
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          stable_q;
      logic          stable_d;
      logic          press_q;
      logic          press_d;
      logic          rel_q;
      logic          rel_d;

      // Count consecutive samples that disagree with the accepted level.
      // Accept the new level on the DEBOUNCE_CYCLES-th such sample. Any
      // agreeing sample restarts the count, so short glitches are dropped.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        if (samp_s[gi] == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = samp_s[gi];
          cnt_d    = '0;
          press_d  = samp_s[gi];
          rel_d    = ~samp_s[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Channel state. Pulses are registered with the level, so each pulse
      // lands in the same cycle as the level change it marks.
      always_ff @(posedge clock_50) begin
        if (reset) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          press_q  <= 1'b0;
          rel_q    <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
          press_q  <= press_d;
          rel_q    <= rel_d;
        end
      end

      assign key_level[gi]   = stable_q;
      assign key_press[gi]   = press_q;
      assign key_release[gi] = rel_q;
    end
  endgenerate

  // Reset sequencer:
  //   HOLD   - core held in reset while the hold period counts down.
  //   RUN    - core released.
  //   KEYRST - manual reset key is down; core held in reset.
  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_KEYRST = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;

  // Next-state logic. The hold counter is cleared whenever we are not in
  // HOLD, so every entry into HOLD gives a full hold period.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        hold_d = '0;
        if (key_level[RESET_KEY]) begin
          state_d = ST_KEYRST;
        end
      end
      ST_KEYRST: begin
        hold_d = '0;
        if (!key_level[RESET_KEY]) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase
  end

  // Sequencer state register. Reset overrides everything, including KEYRST.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Both reset outputs are decoded straight from the registered state, so
  // they are glitch-free.
  assign rst_n_out = (state_q == ST_RUN);
  assign rst_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_key_reset_sequencer.sv
// Self-checking bench for key_reset_sequencer.
// A behavioural model, built from run-length and countdown rules, is checked
// against the DUT after every clock edge. Literal checks at the scenario
// boundaries pin down the model itself. These are followed by randomized
// key activity with occasional resets.
module tb_key_reset_sequencer;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int H  = 5;
  localparam int RK = 0;
`ifdef KEY_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         rst_n_out;
  logic         rst_done;

  int n_checks = 0;
  int n_fail   = 0;

  key_reset_sequencer #(
    .N_KEYS            (N),
    .DEBOUNCE_CYCLES   (D),
    .RESET_HOLD_CYCLES (H),
    .RESET_KEY         (RK)
  ) dut (
    .clock_50    (clk),
    .reset       (reset),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .rst_n_out   (rst_n_out),
    .rst_done    (rst_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;
  logic [N-1:0] m_s1    = '0;
  logic [N-1:0] m_s2    = '0;
  logic [N-1:0] m_samp;
  int           m_run [N];        // length of current run of samples differing from level
  int           m_hold_left = H;  // hold cycles still to go before the core is released
  bit           m_core_run = 0;
  bit           m_key_rst  = 0;
  bit           started    = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_level = '0; m_press = '0; m_rel = '0; m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_hold_left = H; m_core_run = 0; m_key_rst = 0;
      started = 1;
    end else begin
      // The sequencer reacts to the level that was visible before this edge.
      if (m_key_rst) begin
        if (!m_level[RK]) begin m_key_rst = 0; m_hold_left = H; end
      end else if (m_core_run) begin
        if (m_level[RK]) begin m_core_run = 0; m_key_rst = 1; end
      end else begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) m_core_run = 1;
      end
`ifdef KEY_SYNC_EN
      m_samp = m_s2; m_s2 = m_s1; m_s1 = ~key_n;
`else
      m_samp = ~key_n;
`endif
      m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin
        if (m_samp[i] == m_level[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_level[i] = m_samp[i];
            m_run[i]   = 0;
            if (m_samp[i]) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
          end
        end
      end
    end
    #1;
    if (started) begin
      n_checks++;
      if (key_level !== m_level || key_press !== m_press || key_release !== m_rel ||
          rst_n_out !== m_core_run || rst_done !== m_core_run) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got lvl=%b prs=%b rel=%b rstn=%b done=%b want lvl=%b prs=%b rel=%b rstn=%b done=%b",
                 $time, key_level, key_press, key_release, rst_n_out, rst_done,
                 m_level, m_press, m_rel, m_core_run, m_core_run);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end else begin
      $display("ok   %s t=%0t value=%0h", name, $time, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int dur [N];

  initial begin
    // Power-on release: three reset edges, then the hold sequence.
    reset = 1'b1; key_n = 4'hF;
    step(3);
    reset = 1'b0;
    step(4);
    check("por_rstn_edge4", 32'(rst_n_out), 32'd0);
    check("por_done_edge4", 32'(rst_done), 32'd0);
    check("por_level", 32'(key_level), 32'd0);
    step(1);
    check("por_rstn_edge5", 32'(rst_n_out), 32'd1);
    check("por_done_edge5", 32'(rst_done), 32'd1);

    // Glitch rejection: a 10-cycle press is shorter than the debounce window.
    key_n[1] = 1'b0;
    step(10);
    key_n[1] = 1'b1;
    step(LAT + 2);
    check("glitch_level1", 32'(key_level[1]), 32'd0);

    // Clean press and release on channel 2.
    key_n[2] = 1'b0;
    step(LAT - 1);
    check("press_early_level", 32'(key_level[2]), 32'd0);
    check("press_early_pulse", 32'(key_press[2]), 32'd0);
    step(1);
    check("press_pulse", 32'(key_press[2]), 32'd1);
    check("press_level", 32'(key_level[2]), 32'd1);
    step(1);
    check("press_pulse_one_cycle", 32'(key_press[2]), 32'd0);
    step(40 - LAT - 1);
    key_n[2] = 1'b1;
    step(LAT - 1);
    check("release_early", 32'(key_release[2]), 32'd0);
    step(1);
    check("release_pulse", 32'(key_release[2]), 32'd1);
    check("release_level", 32'(key_level[2]), 32'd0);
    step(1);
    check("release_one_cycle", 32'(key_release[2]), 32'd0);

    // Manual reset through key 0.
    key_n[0] = 1'b0;
    step(LAT);
    check("mrst_level_up", 32'(key_level[0]), 32'd1);
    check("mrst_rstn_still_high", 32'(rst_n_out), 32'd1);
    step(1);
    check("mrst_rstn_low", 32'(rst_n_out), 32'd0);
    check("mrst_done_low", 32'(rst_done), 32'd0);
    step(30 - LAT - 1);
    key_n[0] = 1'b1;
    step(LAT);
    check("mrst_level_down", 32'(key_level[0]), 32'd0);
    step(5);
    check("mrst_rstn_plus5", 32'(rst_n_out), 32'd0);
    step(1);
    check("mrst_rstn_plus6", 32'(rst_n_out), 32'd1);

    // Reset in the middle of operation: FSM in KEYRST, channel 3 mid-count.
    key_n[0] = 1'b0;
    step(LAT + 1);
    check("mid_in_keyrst", 32'(rst_n_out), 32'd0);
    key_n[3] = 1'b0;
    step(10);
    reset = 1'b1;
    key_n = 4'b0111;
    step(1);
    check("mid_reset_outputs", 32'({key_level, key_press, key_release, rst_n_out, rst_done}), 32'd0);
    reset = 1'b0;
    step(4);
    check("mid_rstn_edge4", 32'(rst_n_out), 32'd0);
    step(1);
    check("mid_rstn_edge5", 32'(rst_n_out), 32'd1);
    step(LAT - 1 - 5);
    check("mid_ch3_restart_early", 32'(key_level[3]), 32'd0);
    step(1);
    check("mid_ch3_restart_level", 32'(key_level[3]), 32'd1);
    key_n = 4'hF;
    step(LAT + 2);

    // Randomized activity on all keys, with an occasional reset.
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          key_n[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 2) == 0) dur[i] = int'($urandom_range(1, 6));
          else dur[i] = int'($urandom_range(D - 2, D + 24));
        end
        dur[i] = dur[i] - 1;
      end
      reset = ($urandom_range(0, 399) == 0);
      step(1);
    end
    reset = 1'b0;
    key_n = 4'hF;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
